lighthouse_frame_decoder: RTL and testbench

//   Sits directly downstream of PulseIntervalDetector and consumes its interval/ready stream.

---
 rtl/lighthouse_frame_decoder_if.sv | 22 ++
 rtl/lighthouse_frame_decoder.sv | 118 +++++++++++
 tb/tb_lighthouse_frame_decoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lighthouse_frame_decoder_if.sv
// Interval stream in, decoded frame results out, for lighthouse_frame_decoder.
// master drives intervals; slave is the decoder.
interface lighthouse_frame_decoder_if;
  logic [31:0] interval;
  logic        in_valid;
  logic [31:0] sweep_pos;
  logic [31:0] period;
  logic        out_valid;
  logic [15:0] frame_ok_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  modport master (
    output interval, in_valid,
    input  sweep_pos, period, out_valid, frame_ok_cnt, err_cnt, state
  );

  modport slave (
    input  interval, in_valid,
    output sweep_pos, period, out_valid, frame_ok_cnt, err_cnt, state
  );
endinterface

// File: rtl/lighthouse_frame_decoder.sv
// Lighthouse frame decoder: assembles sync gap, sweep and tail intervals into a frame,
// range-checks the period and reports sweep position plus good/bad frame counts.
module lighthouse_frame_decoder #(
  parameter int unsigned SYNC_GAP_MAX = 8,
  parameter int unsigned PERIOD_MIN   = 90,
  parameter int unsigned PERIOD_MAX   = 110
) (
  input logic                         clk,
  input logic                         rst,
  lighthouse_frame_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    StHunt     = 2'd0,
    StGotSync  = 2'd1,
    StGotSweep = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [31:0] l1_q, l1_d;
  logic [31:0] sweep_pos_q, sweep_pos_d;
  logic [31:0] period_q, period_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        is_short;
  logic        err_inc;
  logic [33:0] psum;
  logic        in_range;

  assign is_short = (bus.interval <= SYNC_GAP_MAX);
  // 34-bit sum so an overflowing period can never alias into the accept window.
  assign psum     = {2'b00, s_q} + {2'b00, l1_q} + {2'b00, bus.interval};
  assign in_range = (psum >= 34'(PERIOD_MIN)) && (psum <= 34'(PERIOD_MAX));

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    l1_d        = l1_q;
    sweep_pos_d = sweep_pos_q;
    period_d    = period_q;
    out_valid_d = 1'b0;
    ok_cnt_d    = ok_cnt_q;
    err_inc     = 1'b0;

    if (bus.in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (is_short) begin
            state_d = StGotSync;
            s_d     = bus.interval;
          end
        end
        StGotSync: begin
          if (is_short) begin
            s_d     = bus.interval;
            err_inc = 1'b1;
          end else begin
            state_d = StGotSweep;
            l1_d    = bus.interval;
          end
        end
        StGotSweep: begin
          if (is_short) begin
            state_d = StGotSync;
            s_d     = bus.interval;
            err_inc = 1'b1;
          end else begin
            state_d = StHunt;
            if (in_range) begin
              sweep_pos_d = l1_q;
              period_d    = (psum[33:32] != 2'b00) ? 32'hFFFF_FFFF : psum[31:0];
              out_valid_d = 1'b1;
              ok_cnt_d    = ok_cnt_q + 16'd1;
            end else begin
              err_inc = 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StHunt;
      s_q         <= '0;
      l1_q        <= '0;
      sweep_pos_q <= '0;
      period_q    <= '0;
      out_valid_q <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      l1_q        <= l1_d;
      sweep_pos_q <= sweep_pos_d;
      period_q    <= period_d;
      out_valid_q <= out_valid_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.sweep_pos    = sweep_pos_q;
  assign bus.period       = period_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.frame_ok_cnt = ok_cnt_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_lighthouse_frame_decoder.sv
// Scoreboard bench for lighthouse_frame_decoder: stimulus queues expected strobes,
// an independent monitor pops and compares them.
module tb_lighthouse_frame_decoder;

  logic clk;
  logic rst;

  lighthouse_frame_decoder_if bus ();

  lighthouse_frame_decoder #(
    .SYNC_GAP_MAX(8),
    .PERIOD_MIN  (90),
    .PERIOD_MAX  (110)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] sweep_pos;
    logic [31:0] period;
    logic [15:0] ok_cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got sweep_pos=%0d period=%0d expected no strobe",
                 bus.sweep_pos, bus.period);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_sweep_pos", 64'(bus.sweep_pos), 64'(e.sweep_pos));
        check("strobe_period", 64'(bus.period), 64'(e.period));
        check("strobe_ok_cnt", 64'(bus.frame_ok_cnt), 64'(e.ok_cnt));
      end
    end
  end

  task automatic drive(input logic [31:0] v);
    bus.interval = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    drive(a);
    drive(b);
    drive(c);
  endtask

  task automatic expect_strobe(input logic [31:0] sp, input logic [31:0] per,
                               input logic [15:0] ok);
    exp_t e;
    e.sweep_pos = sp;
    e.period    = per;
    e.ok_cnt    = ok;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    bus.interval = '0;
    bus.in_valid = 1'b0;
    #3;
    check("rst_state", 64'(bus.state), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sweep_pos", 64'(bus.sweep_pos), 64'd0);
    check("rst_period", 64'(bus.period), 64'd0);
    check("rst_ok_cnt", 64'(bus.frame_ok_cnt), 64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Nominal frame
    expect_strobe(32'd50, 32'd100, 16'd1);
    frame(32'd3, 32'd50, 32'd47);
    drain("nominal_drain");

    // Back-to-back frames
    expect_strobe(32'd20, 32'd103, 16'd2);
    expect_strobe(32'd70, 32'd103, 16'd3);
    frame(32'd3, 32'd20, 32'd80);
    frame(32'd3, 32'd70, 32'd30);
    drain("b2b_drain");

    // Period window edges: 90 and 110 accepted, 89 and 111 rejected
    expect_strobe(32'd50, 32'd90, 16'd4);
    frame(32'd3, 32'd50, 32'd37);
    expect_strobe(32'd50, 32'd110, 16'd5);
    frame(32'd3, 32'd50, 32'd57);
    frame(32'd3, 32'd50, 32'd36);
    frame(32'd3, 32'd50, 32'd58);
    check("edge_err_cnt", 64'(bus.err_cnt), 64'd2);
    check("edge_state", 64'(bus.state), 64'd0);
    check("edge_hold_period", 64'(bus.period), 64'd110);

    // Sync gap edges: 8 and 0 are SHORT, 9 is LONG
    expect_strobe(32'd9, 32'd97, 16'd6);
    frame(32'd8, 32'd9, 32'd80);
    expect_strobe(32'd50, 32'd100, 16'd7);
    frame(32'd0, 32'd50, 32'd50);
    drain("gap_drain");

    // Out-of-range period
    frame(32'd3, 32'd50, 32'd100);
    check("oor_err_cnt", 64'(bus.err_cnt), 64'd3);
    check("oor_state", 64'(bus.state), 64'd0);
    check("oor_hold_sweep", 64'(bus.sweep_pos), 64'd50);
    check("oor_hold_period", 64'(bus.period), 64'd100);
    drain("oor_drain");

    // Sequence errors: double sync, then missing sweep
    drive(32'd3);
    expect_strobe(32'd50, 32'd100, 16'd8);
    frame(32'd3, 32'd50, 32'd47);
    check("dblsync_err_cnt", 64'(bus.err_cnt), 64'd4);
    frame(32'd3, 32'd50, 32'd4);
    check("nosweep_err_cnt", 64'(bus.err_cnt), 64'd5);
    check("nosweep_state", 64'(bus.state), 64'd1);
    drain("seq_drain");

    // Asynchronous reset mid-frame
    drive(32'd50);
    check("midframe_state", 64'(bus.state), 64'd2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_state", 64'(bus.state), 64'd0);
    check("async_sweep_pos", 64'(bus.sweep_pos), 64'd0);
    check("async_period", 64'(bus.period), 64'd0);
    check("async_ok_cnt", 64'(bus.frame_ok_cnt), 64'd0);
    check("async_err_cnt", 64'(bus.err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // A LONG right after reset is ignored without error
    drive(32'd50);
    check("post_rst_state", 64'(bus.state), 64'd0);
    check("post_rst_err", 64'(bus.err_cnt), 64'd0);

    // Overflowing period is rejected
    frame(32'd3, 32'hFFFF_FFF0, 32'h100);
    check("sat_err_cnt", 64'(bus.err_cnt), 64'd1);
    check("sat_state", 64'(bus.state), 64'd0);
    check("sat_period", 64'(bus.period), 64'd0);
    check("sat_ok_cnt", 64'(bus.frame_ok_cnt), 64'd0);

    // 260 double-sync errors saturate the error counter
    repeat (261) drive(32'd3);
    check("err_saturate", 64'(bus.err_cnt), 64'd255);

    // Counters stay independent while errors are saturated
    expect_strobe(32'd50, 32'd100, 16'd1);
    drive(32'd50);
    drive(32'd47);
    check("final_err_cnt", 64'(bus.err_cnt), 64'd255);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
